soc_system_pio_irq: RTL
=======================

Name: soc_system_pio_irq

Overview:
- Parametrised Avalon-MM general-purpose I/O port; next generation of the team's fixed 8-bit output-only PIO.
- Adds per-bit direction, an input synchroniser and edge capture with write-1-to-clear.
- Adds a maskable, registered interrupt and atomic set/clear of output bits.
- Sits on the HPS lightweight bridge and drives and senses intersection signals: lamps, sensors, buttons.

Parameters:
WIDTH, 8, port width in bits, 1..32
RESET_VALUE, 0, reset value of the output data register (WIDTH bits)
EDGE_TYPE, 1, edge capture type: 0 none, 1 rising, 2 falling, 3 any
IRQ_TYPE, 2, interrupt type: 0 none (irq tied 0), 1 level, 2 edge
SYNC_STAGES, 2, input synchroniser depth, 2..4

Ports:
clk  input  1  system clock; single clock domain
reset_n  input  1  asynchronous active-low reset
address  input  3  Avalon word address
chipselect  input  1  slave select
write_n  input  1  active-low write strobe
writedata  input  32  write data
readdata  output  32  read data, combinational, zero wait states
in_port  input  WIDTH  asynchronous pin inputs
out_port  output  WIDTH  output data register
oe_port  output  WIDTH  direction register; 1 = bit driven as output
irq  output  1  registered interrupt request, active high

Behaviour:
- Reset: data_out=RESET_VALUE, dir=0, mask=0, edge_cap=0, all synchroniser stages and in_prev=0, irq=0, prime counter=0.
- wr = chipselect & ~write_n. Only writedata[WIDTH-1:0] is used.
- Register map. All writes take effect at the next clk edge.
  - addr 0, data. Write sets data_out. Read returns per bit dir ? data_out : in_sync.
  - addr 1, direction. Read/write.
  - addr 2, interrupt mask. Read/write.
  - addr 3, edge capture. Read returns edge_cap. Write: each 1 bit clears that bit.
  - addr 4, outset: data_out |= wd.
  - addr 5, outclear: data_out &= ~wd.
  - addr 6 and 7: read 0, writes ignored.
- readdata bits [31:WIDTH] always 0. readdata = 0 when chipselect is low.
- Synchroniser: SYNC_STAGES flops. in_sync is the last stage. in_prev is in_sync delayed by one cycle.
- Edge detect, combinational:
  - rise = in_sync & ~in_prev
  - fall = ~in_sync & in_prev
  - sel = rise, fall or rise|fall according to EDGE_TYPE; 0 when EDGE_TYPE is 0.
- Edge qualification:
  - Qualified only for input bits (dir=0).
  - Qualified only when prime counter = SYNC_STAGES+1.
  - The prime counter increments each cycle after reset until it reaches SYNC_STAGES+1, then saturates. This suppresses false edges from reset-state synchroniser contents.
- edge_cap update: edge_cap <= (edge_cap & ~clr) | (sel & ~dir & primed). clr is the addr-3 write mask. A simultaneous new edge and clear on the same bit leaves the bit set; set wins and no event is lost.
- irq, registered, updated every cycle:
  - IRQ_TYPE 1: irq <= |(in_sync & ~dir & mask)
  - IRQ_TYPE 2: irq <= |(edge_cap & mask)
  - IRQ_TYPE 0: irq stays 0.
- Latency with SYNC_STAGES=2, in_port toggling just before edge N:
  - in_sync updates at edge N+1.
  - edge_cap bit sets at edge N+2.
  - irq asserts at edge N+3.
  - irq deasserts one cycle after the clearing write or mask write.
- Changing dir from 1 to 0 on a bit does not itself create an edge. Edges are judged on in_sync/in_prev only, which run continuously regardless of dir.
- reset_n asserted mid-operation: all state returns to reset values immediately (asynchronous); irq drops without a clock.
- out_port = data_out and oe_port = dir, both directly from registers with no combinational path from the bus.

Test Plan:
- Reset, then read addrs 0..7 with dir=0, in_port=0 (WIDTH=8, RESET_VALUE=8'hA5) -> out_port=8'hA5, oe_port=0, all reads 0, irq=0.
- Write addr0=8'h0F, addr4=8'hC0, addr5=8'h03 -> out_port 8'h0F, then 8'hCF, then 8'hCC. Write dir=8'hFF, read addr0 -> 8'hCC.
- EDGE_TYPE=1, IRQ_TYPE=2, mask=8'h01, dir=0: raise in_port[0] -> addr3 reads 8'h01 two cycles later, irq=1 three cycles later. Write addr3=8'h01 -> irq=0 next cycle after clear.
- Drive a new rising edge on bit 0 in the same cycle as the addr3=8'h01 clear write -> edge_cap[0] stays 1, irq stays 1.
- Hold in_port=8'hFF through reset release -> no edge_cap bits set, irq=0. Then a falling-then-rising pulse on bit 3 -> edge_cap=8'h08.
- IRQ_TYPE=1, mask=8'h04: in_port[2]=1 -> irq=1. Assert reset_n=0 mid-cycle -> irq=0 asynchronously, out_port=RESET_VALUE.

Source files
------------

// File: rtl/soc_system_pio_irq_if.sv
// Avalon-MM slave bus bundle for the PIO block.
//   address    : word address (3 bits)
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : write data (32 bits)
//   readdata   : read data (32 bits), combinational, zero wait states
// master = bridge side, slave = PIO side.
interface soc_system_pio_irq_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/soc_system_pio_irq.sv
// Parametrised Avalon-MM general-purpose I/O port with per-bit direction,
// input synchroniser, edge capture (write-1-to-clear), maskable registered
// interrupt and atomic set/clear of output bits.
//   clk, reset_n : single clock, asynchronous active-low reset
//   bus          : Avalon-MM slave (address, chipselect, write_n, writedata, readdata)
//   in_port      : asynchronous pin inputs
//   out_port     : output data register
//   oe_port      : direction register, 1 = bit driven as output
//   irq          : registered interrupt request, active high
// Register map: 0 data, 1 direction, 2 irq mask, 3 edge capture (W1C),
//               4 outset, 5 outclear, 6/7 reserved (read 0).

// Per-bit input path: synchroniser, previous-value flop, edge capture bit.
module soc_system_pio_irq_lane #(
    parameter int EDGE_TYPE   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin_i,
    input  logic dir_i,
    input  logic primed_i,
    input  logic clr_i,
    output logic sync_o,
    output logic cap_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   cap_q, cap_d;
    logic                   rise, fall, sel;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            cap_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
            prev_q <= sync_q[SYNC_STAGES-1];
            cap_q  <= cap_d;
        end
    end

    always_comb begin
        rise = sync_q[SYNC_STAGES-1] & ~prev_q;
        fall = ~sync_q[SYNC_STAGES-1] & prev_q;
        case (EDGE_TYPE)
            1:       sel = rise;
            2:       sel = fall;
            3:       sel = rise | fall;
            default: sel = 1'b0;
        endcase
        // Set has priority over clear so an edge coinciding with a clear is kept.
        cap_d = (cap_q & ~clr_i) | (sel & ~dir_i & primed_i);
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign cap_o  = cap_q;
endmodule

module soc_system_pio_irq #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               EDGE_TYPE   = 1,
    parameter int               IRQ_TYPE    = 2,
    parameter int               SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    soc_system_pio_irq_if.slave bus,
    input  logic [WIDTH-1:0]   in_port,
    output logic [WIDTH-1:0]   out_port,
    output logic [WIDTH-1:0]   oe_port,
    output logic               irq
);
    localparam logic [2:0] PRIME_MAX = 3'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic             irq_q, irq_d;
    logic [2:0]       prime_q, prime_d;

    logic             wr, primed;
    logic [WIDTH-1:0] wd, clr;
    logic [WIDTH-1:0] in_sync, edge_cap;
    logic [31:0]      rdata;

    assign wr     = bus.chipselect & ~bus.write_n;
    assign wd     = bus.writedata[WIDTH-1:0];
    // Edges are ignored until the synchroniser and in_prev hold real pin
    // samples instead of their reset contents.
    assign primed = (prime_q == PRIME_MAX);

    generate
        if (WIDTH < 32) begin : g_wd_hi
            logic unused_wd_hi;
            assign unused_wd_hi = ^bus.writedata[31:WIDTH];
        end
        for (genvar i = 0; i < WIDTH; i++) begin : g_lane
            soc_system_pio_irq_lane #(
                .EDGE_TYPE  (EDGE_TYPE),
                .SYNC_STAGES(SYNC_STAGES)
            ) u_lane (
                .clk     (clk),
                .reset_n (reset_n),
                .pin_i   (in_port[i]),
                .dir_i   (dir_q[i]),
                .primed_i(primed),
                .clr_i   (clr[i]),
                .sync_o  (in_sync[i]),
                .cap_o   (edge_cap[i])
            );
        end
    endgenerate

    // Register writes.
    always_comb begin
        data_d = data_q;
        dir_d  = dir_q;
        mask_d = mask_q;
        clr    = '0;
        if (wr) begin
            case (bus.address)
                3'd0:    data_d = wd;
                3'd1:    dir_d  = wd;
                3'd2:    mask_d = wd;
                3'd3:    clr    = wd;
                3'd4:    data_d = data_q | wd;
                3'd5:    data_d = data_q & ~wd;
                default: ;
            endcase
        end
    end

    always_comb begin
        prime_d = primed ? prime_q : prime_q + 3'd1;
        case (IRQ_TYPE)
            1:       irq_d = |(in_sync & ~dir_q & mask_q);
            2:       irq_d = |(edge_cap & mask_q);
            default: irq_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= RESET_VALUE;
            dir_q   <= '0;
            mask_q  <= '0;
            irq_q   <= 1'b0;
            prime_q <= '0;
        end else begin
            data_q  <= data_d;
            dir_q   <= dir_d;
            mask_q  <= mask_d;
            irq_q   <= irq_d;
            prime_q <= prime_d;
        end
    end

    // Read mux: zero-extended, and zero whenever the slave is not selected.
    always_comb begin
        rdata = '0;
        if (bus.chipselect) begin
            case (bus.address)
                3'd0:    rdata[WIDTH-1:0] = (dir_q & data_q) | (~dir_q & in_sync);
                3'd1:    rdata[WIDTH-1:0] = dir_q;
                3'd2:    rdata[WIDTH-1:0] = mask_q;
                3'd3:    rdata[WIDTH-1:0] = edge_cap;
                default: rdata = '0;
            endcase
        end
    end

    assign bus.readdata = rdata;
    assign out_port     = data_q;
    assign oe_port      = dir_q;
    assign irq          = irq_q;
endmodule
